int_to_float_seq: RTL and testbench

- Multi-cycle converter from a 32-bit integer (signed or unsigned) to an IEEE-754 single-precision value. It is the companion of the existing float-to-integer converter in the floating-point unit.
- Used by the FPU for cvt.s.w-style operations.
- Normalises with an iterative leading-zero shifter, then applies round-to-nearest-even.
- Valid/ready handshake on input and output; one conversion in flight at a time.

---
 rtl/fp_pkg.sv | 32 +++
 rtl/fp_round_rne.sv | 45 ++++
 rtl/int_to_float_seq.sv | 140 ++++++++++++++
 tb/tb_int_to_float_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point constants, types and packing helper
//
// Purpose: common definitions for the single-precision conversion datapaths.
//   FP_BIAS / FP_EXP_W / FP_FRAC_W : IEEE-754 single-precision field geometry
//   i2f_state_t                    : integer-to-float sequencer states
//   I2F_EXP_INIT                   : exponent of a 32-bit magnitude whose MSB is bit 31
//   fp_pack()                      : assemble {sign, exponent, fraction}
package fp_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;

  // A magnitude with its leading one at bit 31 represents 1.x * 2^31.
  localparam logic [8:0] I2F_EXP_INIT = 9'(FP_BIAS + 31);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } i2f_state_t;

  function automatic logic [31:0] fp_pack(
    input logic                 sign_f,
    input logic [FP_EXP_W-1:0]  exp_f,
    input logic [FP_FRAC_W-1:0] frac_f
  );
    return {sign_f, exp_f, frac_f};
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// rtl/fp_round_rne.sv - round-to-nearest-even of a normalised 32-bit magnitude
//
// Purpose: combinational rounding of a normalised magnitude (leading one at
// bit 31) down to a 23-bit fraction with round-to-nearest, ties-to-even.
// Ports:
//   mag_i     in  32  normalised magnitude, implicit one at bit 31
//   exp_i     in  9   biased exponent matching mag_i
//   exp_o     out 9   exponent after a possible rounding carry-out
//   frac_o    out 23  rounded fraction
//   inexact_o out 1   guard or sticky bit was set
module fp_round_rne
  import fp_pkg::*;
(
  input  logic [31:0]          mag_i,
  input  logic [8:0]           exp_i,
  output logic [8:0]           exp_o,
  output logic [FP_FRAC_W-1:0] frac_o,
  output logic                 inexact_o
);

  logic [FP_FRAC_W-1:0] frac_trunc;
  logic                 guard_bit;
  logic                 sticky_bit;
  logic                 round_up;
  logic [FP_FRAC_W:0]   frac_sum;
  logic                 unused_msb;

  assign frac_trunc = mag_i[30:8];
  assign guard_bit  = mag_i[7];
  assign sticky_bit = |mag_i[6:0];

  // Exact halfway cases round only when the kept LSB is odd.
  assign round_up   = guard_bit & (sticky_bit | frac_trunc[0]);
  assign frac_sum   = {1'b0, frac_trunc} + {{FP_FRAC_W{1'b0}}, round_up};

  // A carry out of the fraction means 1.111..1 rounded to 10.000..0: the
  // wrapped fraction is already zero, so only the exponent moves.
  assign frac_o     = frac_sum[FP_FRAC_W-1:0];
  assign exp_o      = exp_i + {8'd0, frac_sum[FP_FRAC_W]};
  assign inexact_o  = guard_bit | sticky_bit;

  // Bit 31 is the implicit leading one and is not stored.
  assign unused_msb = mag_i[31];

endmodule

// File: rtl/int_to_float_seq.sv
// rtl/int_to_float_seq.sv - multi-cycle 32-bit integer to IEEE single converter
//
// Purpose: converts a signed or unsigned 32-bit integer to single precision.
// The magnitude is normalised by an iterative leading-zero shifter (coarse
// LZ_STEP shifts, then single-bit shifts), then rounded to nearest-even.
// One conversion is in flight at a time.
// Parameters:
//   LZ_STEP     coarse shift per normalise cycle (1, 2, 4, 8 or 16)
// Ports:
//   clock       in  1   system clock, rising edge
//   reset_n     in  1   asynchronous active-low reset
//   in_valid    in  1   operand present
//   in_ready    out 1   converter idle, operand accepted on in_valid
//   in_data     in  32  integer operand
//   in_unsigned in  1   1 = unsigned operand, 0 = two's complement
//   out_valid   out 1   result present
//   out_ready   in  1   consumer accepts the result
//   out_data    out 32  IEEE single result
//   out_inexact out 1   result was rounded
module int_to_float_seq
  import fp_pkg::*;
#(
  parameter int LZ_STEP = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_unsigned,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inexact
);

  localparam logic [8:0] STEP_EXP = 9'(LZ_STEP);

  i2f_state_t  state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [8:0]  exp_q, exp_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_inexact_q, out_inexact_d;

  logic [8:0]           rnd_exp;
  logic [FP_FRAC_W-1:0] rnd_frac;
  logic                 rnd_inexact;
  logic                 unused_exp_msb;

  fp_round_rne u_round (
    .mag_i     (mag_q),
    .exp_i     (exp_q),
    .exp_o     (rnd_exp),
    .frac_o    (rnd_frac),
    .inexact_o (rnd_inexact)
  );

  // The reachable exponent never exceeds 159, so bit 8 is always clear.
  assign unused_exp_msb = rnd_exp[8];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      sign_q        <= 1'b0;
      mag_q         <= 32'd0;
      exp_q         <= 9'd0;
      out_data_q    <= 32'd0;
      out_inexact_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sign_q        <= sign_d;
      mag_q         <= mag_d;
      exp_q         <= exp_d;
      out_data_q    <= out_data_d;
      out_inexact_q <= out_inexact_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    sign_d        = sign_q;
    mag_d         = mag_q;
    exp_d         = exp_q;
    out_data_d    = out_data_q;
    out_inexact_d = out_inexact_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d  = ~in_unsigned & in_data[31];
          // Negating 0x80000000 wraps back to 0x80000000, the correct
          // unsigned magnitude of the most negative operand.
          mag_d   = sign_d ? (~in_data + 32'd1) : in_data;
          exp_d   = I2F_EXP_INIT;
          state_d = NORM;
        end
      end

      NORM: begin
        if ((mag_q == 32'd0) || mag_q[31]) begin
          state_d = ROUND;
        end else if (mag_q[31 -: LZ_STEP] == '0) begin
          // Coarse step is taken only when it cannot shift the leading one out.
          mag_d = mag_q << LZ_STEP;
          exp_d = exp_q - STEP_EXP;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 9'd1;
        end
      end

      ROUND: begin
        if (mag_q == 32'd0) begin
          // Zero is always +0 and exact, whatever the operand sign was.
          out_data_d    = 32'd0;
          out_inexact_d = 1'b0;
        end else begin
          out_data_d    = fp_pack(sign_q, rnd_exp[7:0], rnd_frac);
          out_inexact_d = rnd_inexact;
        end
        state_d = DONE;
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_data    = out_data_q;
  assign out_inexact = out_inexact_q;

endmodule

// File: tb/tb_int_to_float_seq.sv
// tb/tb_int_to_float_seq.sv - self-checking bench for int_to_float_seq
module tb_int_to_float_seq;

  localparam int LZ = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_unsigned;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_inexact;

  always #5 clock = ~clock;

  int_to_float_seq #(.LZ_STEP(LZ)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_unsigned (in_unsigned),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_inexact (out_inexact)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        inexact;
    logic [7:0]  lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Cycles from accept edge to out_valid: coarse steps while at least LZ
  // leading zeros remain, then single steps, plus NORM exit and ROUND.
  function automatic int model_lat(input logic [31:0] d, input logic u);
    logic [31:0] m;
    int lz;
    m = (!u && d[31]) ? (~d + 32'd1) : d;
    if (m == 32'd0) return 2;
    lz = 0;
    for (int i = 31; i >= 0; i--) begin
      if (m[i]) break;
      lz++;
    end
    return lz / LZ + lz % LZ + 2;
  endfunction

  task automatic send(input logic [31:0] d, input logic u, input logic [31:0] ed,
                      input logic ei, input bit push);
    exp_t e;
    in_data     = d;
    in_unsigned = u;
    in_valid    = 1'b1;
    chk("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    if (push) begin
      e.data    = ed;
      e.inexact = ei;
      e.lat     = 8'(model_lat(d, u));
      sb.push_back(e);
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic receive(input string tag, input int hold);
    exp_t e;
    int   n;
    bit   seen;
    logic [31:0] held;
    n    = 0;
    seen = 1'b0;
    while (n < 80 && !seen) begin
      @(posedge clock);
      n++;
      #1;
      seen = out_valid;
    end
    chk({tag, "_valid"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
        e = sb.pop_front();
        chk({tag, "_latency"}, n, {24'd0, e.lat});
        chk({tag, "_data"}, out_data, e.data);
        chk({tag, "_inexact"}, {31'd0, out_inexact}, {31'd0, e.inexact});
        held = e.data;
        for (int i = 0; i < hold; i++) begin
          @(posedge clock);
          #1;
          chk({tag, "_hold_data"}, out_data, held);
          chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
          chk({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
      end
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  task automatic conv(input string tag, input logic [31:0] d, input logic u,
                      input logic [31:0] ed, input logic ei);
    send(d, u, ed, ei, 1'b1);
    receive(tag, 0);
  endtask

  initial begin
    bit saw;
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_data     = 32'd0;
    in_unsigned = 1'b0;
    out_ready   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_inexact", {31'd0, out_inexact}, 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    conv("zero",      32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);
    conv("one",       32'h0000_0001, 1'b0, 32'h3F80_0000, 1'b0);
    conv("minus_one", 32'hFFFF_FFFF, 1'b0, 32'hBF80_0000, 1'b0);
    conv("int_min",   32'h8000_0000, 1'b0, 32'hCF00_0000, 1'b0);
    conv("int_max",   32'h7FFF_FFFF, 1'b0, 32'h4F00_0000, 1'b1);
    conv("tie_even",  32'h0100_0001, 1'b0, 32'h4B80_0000, 1'b1);
    conv("tie_odd",   32'h0100_0003, 1'b0, 32'h4B80_0002, 1'b1);
    conv("exact_lsb", 32'h0100_0002, 1'b0, 32'h4B80_0001, 1'b0);
    conv("u_max",     32'hFFFF_FFFF, 1'b1, 32'h4F80_0000, 1'b1);
    conv("u_msb",     32'h8000_0000, 1'b1, 32'h4F00_0000, 1'b0);
    conv("three",     32'h0000_0003, 1'b0, 32'h4040_0000, 1'b0);
    conv("minus_five", 32'hFFFF_FFFB, 1'b0, 32'hC0A0_0000, 1'b0);

    send(32'h0000_0064, 1'b0, 32'h42C8_0000, 1'b0, 1'b1);
    receive("backpressure", 5);

    // Reset while the shifter is still working on operand 1.
    send(32'h0000_0001, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (out_valid) saw = 1'b1;
    end
    chk("abort_no_output", {31'd0, saw}, 32'd0);
    conv("after_abort", 32'h0000_0005, 1'b0, 32'h40A0_0000, 1'b0);

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
